// File: rtl/filter_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : filter_frame_sequencer_if
// Description : Sample-source stream into the frame sequencer
//               (valid/ready handshake plus sample data).
// Revision    : 1.0 - initial release
// ============================================================================
interface filter_frame_sequencer_if #(
  parameter int DATA_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  // Sample source side
  modport master (output in_valid, output in_data, input in_ready);
  // Sequencer side
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface
`default_nettype wire

// File: rtl/filter_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : filter_frame_sequencer
// Description : Runs the filter one frame at a time: clears it, streams
//               FRAME_LEN samples under clk_enable gating, flushes the
//               pipeline with zeros and tags outputs that carry real samples.
// Revision    : 1.0 - initial release
// ============================================================================
module filter_frame_sequencer #(
  parameter int DATA_W    = 10,
  parameter int FRAME_LEN = 2000,
  parameter int CNT_W     = 11,
  parameter int FILT_LAT  = 1
) (
  input  wire logic              clk,
  input  wire logic              resetn,
  input  wire logic              start,
  input  wire logic              abort,
  filter_frame_sequencer_if.slave src,
  output logic                   filt_reset,
  output logic                   filt_clk_enable,
  output logic [DATA_W-1:0]      filt_in,
  input  wire logic [DATA_W-1:0] filt_out,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   busy,
  output logic                   frame_done,
  output logic [CNT_W-1:0]       sample_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int              FL_W         = (FILT_LAT > 1) ? $clog2(FILT_LAT) : 1;
  localparam logic [CNT_W-1:0] c_last_idx   = CNT_W'(FRAME_LEN - 1);
  localparam logic [FL_W-1:0]  c_flush_last = FL_W'(FILT_LAT - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [FL_W-1:0]       r_flush_cnt;
  logic [FILT_LAT-1:0]   r_tag;
  logic [FILT_LAT-1:0]   w_tag_next;
  logic                  r_en_d;
  logic                  r_filt_reset;
  logic                  w_run;
  logic                  w_flush;
  logic                  w_xfer;
  logic                  w_start_ok;

  assign w_run      = (r_state == S_RUN);
  assign w_flush    = (r_state == S_FLUSH);
  // A transfer only counts when the frame is not being aborted this cycle.
  assign w_xfer     = w_run && src.in_valid && !abort;
  assign w_start_ok = (r_state == S_IDLE) && start && !abort;

  assign src.in_ready = w_run;

  // Filter-side drive: gate the filter on real transfers or flush cycles, zero data otherwise.
  always_comb begin
    filt_clk_enable = 1'b0;
    filt_in         = '0;
    if (!abort) begin
      filt_clk_enable = (w_run && src.in_valid) || w_flush;
    end
    if (w_run) begin
      filt_in = src.in_data;
    end
  end

  // Next-state decode; abort overrides every transition.
  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_next_state = S_CLEAR;
        S_CLEAR: w_next_state = S_RUN;
        S_RUN:   if (src.in_valid && (r_cnt == c_last_idx)) w_next_state = S_FLUSH;
        S_FLUSH: if (r_flush_cnt == c_flush_last) w_next_state = S_DONE;
        S_DONE:  w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Accepted-sample counter: cleared on a new frame, holds its final value until then.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)         r_cnt <= '0;
    else if (w_start_ok) r_cnt <= '0;
    else if (w_xfer)     r_cnt <= r_cnt + CNT_W'(1);
  end

  // Counts flush cycles; parked at zero outside FLUSH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                r_flush_cnt <= '0;
    else if (w_flush && !abort) r_flush_cnt <= r_flush_cnt + FL_W'(1);
    else                        r_flush_cnt <= '0;
  end

  // Tag shift value: a 1 enters only for a real RUN transfer.
  generate
    if (FILT_LAT == 1) begin : g_tag_single
      assign w_tag_next = w_xfer;
    end else begin : g_tag_shift
      assign w_tag_next = {r_tag[FILT_LAT-2:0], w_xfer};
    end
  endgenerate

  // Tag pipe and registered enable track which filter outputs carry real samples.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tag  <= '0;
      r_en_d <= 1'b0;
    end else if (abort || w_start_ok) begin
      r_tag  <= '0;
      r_en_d <= 1'b0;
    end else begin
      r_en_d <= filt_clk_enable;
      if (filt_clk_enable) r_tag <= w_tag_next;
    end
  end

  // Filter reset is registered so it cannot glitch; asserted while in reset and during CLEAR.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_filt_reset <= 1'b1;
    else         r_filt_reset <= (w_next_state == S_CLEAR);
  end

  assign filt_reset = r_filt_reset;
  assign out_valid  = r_en_d & r_tag[FILT_LAT-1];
  assign out_data   = filt_out;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DONE);
  assign sample_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_filter_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_filter_frame_sequencer
// Description : Self-checking bench for filter_frame_sequencer with a
//               delay-line stand-in for the filter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_filter_frame_sequencer;
  localparam int DW  = 10;
  localparam int LEN = 4;
  localparam int LAT = 2;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          filt_reset, filt_clk_enable, out_valid, busy, frame_done;
  logic [DW-1:0] filt_in, filt_out, out_data;
  logic [CW-1:0] sample_cnt;

  int total = 0;
  int bad   = 0;

  filter_frame_sequencer_if #(.DATA_W(DW)) src ();

  filter_frame_sequencer #(
    .DATA_W(DW), .FRAME_LEN(LEN), .CNT_W(CW), .FILT_LAT(LAT)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort), .src(src),
    .filt_reset(filt_reset), .filt_clk_enable(filt_clk_enable), .filt_in(filt_in),
    .filt_out(filt_out), .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .frame_done(frame_done), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  // Filter stand-in: LAT-stage delay advanced only when enabled, synchronously cleared.
  logic [DW-1:0] fpipe [LAT];
  always_ff @(posedge clk) begin
    if (filt_reset) begin
      for (int i = 0; i < LAT; i++) fpipe[i] <= '0;
    end else if (filt_clk_enable) begin
      fpipe[0] <= filt_in;
      for (int i = 1; i < LAT; i++) fpipe[i] <= fpipe[i-1];
    end
  end
  assign filt_out = fpipe[LAT-1];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, leave time for combinational settle.
  task automatic cyc(input logic st, input logic ab, input logic v, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    start = st; abort = ab; src.in_valid = v; src.in_data = d;
    #2;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".filt_reset"}, filt_reset, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".cnt"}, sample_cnt, 0);
    chk({tag, ".in_ready"}, src.in_ready, 0);
    chk({tag, ".clk_en"}, filt_clk_enable, 0);
    chk({tag, ".out_valid"}, out_valid, 0);
    chk({tag, ".frame_done"}, frame_done, 0);
    chk({tag, ".filt_in"}, filt_in, 0);
  endtask

  typedef struct {
    logic          st, v;
    logic [DW-1:0] d;
    logic          rdy, en, ov;
    logic [DW-1:0] od;
    logic          fd, bsy, frst;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input logic v, input int d,
                              input logic rdy, input logic en, input logic ov, input int od,
                              input logic fd, input logic bsy, input logic frst, input int cnt);
    vec_t r;
    r.st = st; r.v = v; r.d = d[DW-1:0];
    r.rdy = rdy; r.en = en; r.ov = ov; r.od = od[DW-1:0];
    r.fd = fd; r.bsy = bsy; r.frst = frst; r.cnt = cnt[CW-1:0];
    return r;
  endfunction

  // Randomized frame: source offers a pre-drawn sample list with random gaps; results
  // must be that list, in order, once each, followed by a single frame_done.
  task automatic run_frame(input int pct, input string tag);
    logic [DW-1:0] samples [LEN];
    int  sent = 0, pulses = 0, dones = 0, cyc_n = 0;
    bit  fin = 0;
    logic vv, ss;
    for (int k = 0; k < LEN; k++) samples[k] = DW'($urandom);
    cyc(1, 0, 0, '0);
    cyc_n = 1;
    while (!fin && cyc_n < 300) begin
      vv = ($urandom_range(0, 99) < pct);
      ss = (sent < LEN) && ($urandom_range(0, 4) == 0);
      cyc(ss, 0, vv, (sent < LEN) ? samples[sent] : DW'($urandom));
      cyc_n++;
      if (cyc_n == 2) chk({tag, ".cnt_cleared"}, sample_cnt, 0);
      if (vv && src.in_ready) sent++;
      if (out_valid) begin
        if (pulses < LEN) chk($sformatf("%s.data%0d", tag, pulses), out_data, samples[pulses]);
        else              chk({tag, ".extra_pulse"}, 1, 0);
        pulses++;
      end
      if (frame_done) begin
        dones++;
        chk({tag, ".cnt_at_done"}, sample_cnt, LEN);
      end
      if (!busy) fin = 1;
    end
    chk({tag, ".finished"}, fin, 1);
    chk({tag, ".pulses"}, pulses, LEN);
    chk({tag, ".dones"}, dones, 1);
    if (pct == 100) chk({tag, ".frame_cycles"}, cyc_n - 1, LEN + LAT + 3);
    else            chk({tag, ".min_cycles"}, (cyc_n - 1) >= (LEN + LAT + 3), 1);
    src.in_valid = 0; start = 0;
  endtask

  initial begin
    int ov_cnt, fd_cnt;
    src.in_valid = 0;
    src.in_data  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #3;
    chk_reset_outputs("reset");
    @(negedge clk) resetn = 1'b1;
    repeat (2) @(posedge clk);

    // Continuous frame
    tbl.push_back(mk(1,0,0,     0,0,0,0,     0,0,0,0));
    tbl.push_back(mk(0,0,0,     0,0,0,0,     0,1,1,0));
    tbl.push_back(mk(0,1,1,     1,1,0,0,     0,1,0,0));
    tbl.push_back(mk(0,1,2,     1,1,0,0,     0,1,0,1));
    tbl.push_back(mk(0,1,3,     1,1,1,1,     0,1,0,2));
    tbl.push_back(mk(0,1,4,     1,1,1,2,     0,1,0,3));
    tbl.push_back(mk(0,0,0,     0,1,1,3,     0,1,0,4));
    tbl.push_back(mk(0,0,0,     0,1,1,4,     0,1,0,4));
    tbl.push_back(mk(0,0,0,     0,0,0,0,     1,1,0,4));
    tbl.push_back(mk(0,0,0,     0,0,0,0,     0,0,0,4));
    // Bubbles in cycles 3 and 4
    tbl.push_back(mk(1,0,0,     0,0,0,0,     0,0,0,4));
    tbl.push_back(mk(0,0,0,     0,0,0,0,     0,1,1,0));
    tbl.push_back(mk(0,1,1,     1,1,0,0,     0,1,0,0));
    tbl.push_back(mk(0,0,0,     1,0,0,0,     0,1,0,1));
    tbl.push_back(mk(0,0,0,     1,0,0,0,     0,1,0,1));
    tbl.push_back(mk(0,1,2,     1,1,0,0,     0,1,0,1));
    tbl.push_back(mk(0,1,3,     1,1,1,1,     0,1,0,2));
    tbl.push_back(mk(0,1,4,     1,1,1,2,     0,1,0,3));
    tbl.push_back(mk(0,0,0,     0,1,1,3,     0,1,0,4));
    tbl.push_back(mk(0,0,0,     0,1,1,4,     0,1,0,4));
    tbl.push_back(mk(0,0,0,     0,0,0,0,     1,1,0,4));
    // start ignored in RUN (cycle 3) and DONE (cycle 8)
    tbl.push_back(mk(1,0,0,     0,0,0,0,     0,0,0,4));
    tbl.push_back(mk(0,0,0,     0,0,0,0,     0,1,1,0));
    tbl.push_back(mk(0,1,'h200, 1,1,0,0,     0,1,0,0));
    tbl.push_back(mk(1,1,'h3FF, 1,1,0,0,     0,1,0,1));
    tbl.push_back(mk(0,1,'h155, 1,1,1,'h200, 0,1,0,2));
    tbl.push_back(mk(0,1,'h0AA, 1,1,1,'h3FF, 0,1,0,3));
    tbl.push_back(mk(0,0,0,     0,1,1,'h155, 0,1,0,4));
    tbl.push_back(mk(0,0,0,     0,1,1,'h0AA, 0,1,0,4));
    tbl.push_back(mk(1,0,0,     0,0,0,0,     1,1,0,4));
    tbl.push_back(mk(0,0,0,     0,0,0,0,     0,0,0,4));
    tbl.push_back(mk(0,0,0,     0,0,0,0,     0,0,0,4));

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t r;
      r = tbl[i];
      cyc(r.st, 0, r.v, r.d);
      chk($sformatf("row%0d.in_ready", i), src.in_ready, r.rdy);
      chk($sformatf("row%0d.clk_en", i), filt_clk_enable, r.en);
      chk($sformatf("row%0d.filt_in", i), filt_in, r.rdy ? r.d : '0);
      chk($sformatf("row%0d.out_valid", i), out_valid, r.ov);
      if (r.ov) chk($sformatf("row%0d.out_data", i), out_data, r.od);
      chk($sformatf("row%0d.frame_done", i), frame_done, r.fd);
      chk($sformatf("row%0d.busy", i), busy, r.bsy);
      chk($sformatf("row%0d.filt_reset", i), filt_reset, r.frst);
      chk($sformatf("row%0d.cnt", i), sample_cnt, r.cnt);
    end

    // abort after two transfers
    cyc(1, 0, 0, '0);
    cyc(0, 0, 0, '0);
    cyc(0, 0, 1, 10'h005);
    cyc(0, 0, 1, 10'h006);
    cyc(0, 1, 1, 10'h007);
    chk("abort.clk_en", filt_clk_enable, 0);
    chk("abort.busy_in_cycle", busy, 1);
    cyc(0, 0, 0, '0);
    chk("abort.idle_next", busy, 0);
    ov_cnt = 0; fd_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) ov_cnt++;
      if (frame_done) fd_cnt++;
      cyc(0, 0, 0, '0);
    end
    chk("abort.no_out_valid", ov_cnt, 0);
    chk("abort.no_frame_done", fd_cnt, 0);

    // start together with abort in IDLE stays idle
    cyc(1, 1, 0, '0);
    cyc(0, 0, 0, '0);
    chk("start_abort.idle", busy, 0);

    run_frame(100, "after_abort");

    // reset mid-FLUSH
    cyc(1, 0, 0, '0);
    cyc(0, 0, 0, '0);
    for (int k = 0; k < LEN; k++) cyc(0, 0, 1, DW'(k + 9));
    @(posedge clk);
    #1 src.in_valid = 0;
    #1 chk("flush.clk_en", filt_clk_enable, 1);
    resetn = 1'b0;
    #1 chk_reset_outputs("flush_reset");
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #3;
    chk("post_reset.busy", busy, 0);
    chk("post_reset.cnt", sample_cnt, 0);

    // randomized frames
    for (int f = 0; f < 10; f++) begin
      run_frame((f % 3 == 0) ? 100 : $urandom_range(30, 90), $sformatf("rnd%0d", f));
      repeat ($urandom_range(0, 3)) cyc(0, 0, 0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/filter_frame_sequencer.md
# filter_frame_sequencer

Sequences the `filter` datapath one frame at a time. It clears the filter and streams exactly FRAME_LEN samples through it under `clk_enable` gating, honouring input backpressure. It then flushes the pipeline with zeros so every real sample's result emerges, and tags the aligned outputs. It sits between the sample source and `u_filter`, owning the filter's `clk_enable`, `reset` and `input_rsvd`.

## Interface
- DATA_W, 10, sample width (sfix10_En3)
- FRAME_LEN, 2000, samples per frame; must be ≥1
- CNT_W, 11, counter width; must be ≥ clog2(FRAME_LEN+1)
- FILT_LAT, 1, number of enabled edges from input presentation to matching `output_rsvd`; must be ≥1

- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- abort  in  1  terminate the current frame immediately
- in_valid  in  1  source sample available
- in_ready  out  1  sequencer accepts the sample this cycle
- in_data  in  DATA_W  source sample, sfix10_En3
- filt_reset  out  1  active-high reset to the filter, registered
- filt_clk_enable  out  1  drives the filter `clk_enable`
- filt_in  out  DATA_W  drives the filter `input_rsvd`
- filt_out  in  DATA_W  from the filter `output_rsvd`
- out_valid  out  1  `out_data` holds the result of a real sample
- out_data  out  DATA_W  equals `filt_out`, unmodified
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse on frame completion
- sample_cnt  out  CNT_W  number of samples accepted in the current frame

## Operation
- FSM states are IDLE, CLEAR, RUN, FLUSH and DONE.
- **IDLE:** `start`=1 moves to CLEAR, with `sample_cnt`←0 and the tag pipe cleared.
- **CLEAR:** lasts exactly 1 cycle with `filt_reset`=1, then moves to RUN.
- **RUN:**
  - `in_ready`=1.
  - A transfer occurs when `in_valid`&`in_ready`.
  - `filt_clk_enable` = `in_valid`, and `filt_in` = `in_data` (combinational).
  - On each transfer, `sample_cnt` increments.
  - The transfer with `sample_cnt`==FRAME_LEN-1 moves to FLUSH.
- **FLUSH:** lasts FILT_LAT cycles with `filt_clk_enable`=1 and `filt_in`=0, then moves to DONE.
- **DONE:** lasts 1 cycle with `frame_done`=1, then moves to IDLE. `sample_cnt` holds FRAME_LEN until the next `start`.
- **Outside RUN/FLUSH:** `in_ready`=0, `filt_clk_enable`=0, `filt_in`=0.
- **Tag pipe:**
  - FILT_LAT bits shift only on edges where `filt_clk_enable`=1.
  - The bit shifted in is 1 for a RUN transfer and 0 for flush or other input.
  - `en_d` is `filt_clk_enable` registered.
  - `out_valid` = `en_d` & tail bit of the tag pipe, so there is exactly one pulse per real sample and never one for flush zeros.
- **abort:** has priority over every transition. From any non-IDLE state, go to IDLE on the next edge, clear the tag pipe and `en_d`, and do not pulse `frame_done`. `filt_clk_enable` is forced to 0 in the abort cycle.
- **start outside IDLE:** ignored, with no effect on state or counters.
- **start and abort together in IDLE:** the FSM stays in IDLE.

## Timing
- **Reset (`resetn`=0):** state IDLE, `sample_cnt`=0, tag pipe=0, `en_d`=0. All outputs are 0 except `filt_reset`=1. The reset is asynchronous and takes effect mid-frame with no completion pulse.
- **Start latency:** `start` sampled at edge E0 puts CLEAR in the cycle after E0 and RUN one cycle later. The first sample can therefore transfer 2 cycles after `start`.
- **Output latency:** a sample transferred in cycle t yields `out_valid` in the cycle after its FILT_LAT-th enabled edge, which is cycle t+FILT_LAT with no bubbles. Bubbles in `in_valid` stretch this latency.
- **`filt_reset`:** registered and glitch-free.
- **Outputs:** `filt_clk_enable` and `in_ready` are Mealy/combinational. `frame_done` and `busy` are decoded from the state register.
- **Frame length:** minimum FRAME_LEN + FILT_LAT + 3 cycles from `start` to the return to IDLE.

## Test plan
- **Continuous frame:** FRAME_LEN=4, FILT_LAT=2, filter modelled as an enabled 2-stage delay. Pulse `start` in cycle 0 and hold `in_valid`=1 with data 0x001..0x004.
  - Transfers occur in cycles 2–5.
  - `out_valid` is high in cycles 4–7 with `out_data` 0x001..0x004.
  - `frame_done` pulses only in cycle 8.
- **Bubbles:** same setup with `in_valid` low in cycles 3 and 4.
  - `filt_clk_enable`=0 in those cycles.
  - Exactly 4 `out_valid` pulses, in order, none duplicated.
  - `frame_done` in cycle 10.
- **start ignored:** pulse `start` again in cycles 3 and 8.
  - No restart and `sample_cnt` unaffected.
  - The cycle-8 pulse (DONE) is ignored, and the next frame begins only on `start` in IDLE.
- **abort mid-RUN:** assert `abort` after 2 transfers.
  - Next cycle is IDLE with `busy`=0.
  - No `frame_done` and no further `out_valid`.
  - A new `start` yields a clean frame with 4 pulses.
- **Reset mid-FLUSH:** drop `resetn` in FLUSH.
  - Asynchronously: `filt_reset`=1 and all other outputs 0.
  - After release, IDLE and `sample_cnt`=0.
- **Full frame:** defaults with the real `filter` and vectors from `input_rsvd.dat` / `output_rsvd_expected.dat`.
  - 2000 `out_valid` pulses, all matching.
  - `sample_cnt`=2000 at `frame_done`, then 0 after the next `start`.
